// File: rtl/segre_mem_arbiter_pkg.sv
// segre_mem_arbiter_pkg: shared types and constants for the memory arbiter.
// Holds the arbiter FSM state encoding and the cache lane geometry.
package segre_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        MMU_IDLE   = 2'd0,
        DCACHE_WB  = 2'd1,
        DCACHE_REQ = 2'd2,
        ICACHE_REQ = 2'd3
    } mmu_state_e;

    localparam int DCACHE_BYTE_SIZE = 16;

endpackage

// File: rtl/segre_mem_arbiter.sv
// segre_mem_arbiter: shares one lane-wide memory port between dcache and icache.
// Optional SEGRE_MEM_ARB_RR_EN alternates grants on conflicts (default: dcache first).
module segre_mem_arbiter
    import segre_mem_arbiter_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int LANE_SIZE = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 dc_miss_i,
    input  logic [ADDR_SIZE-1:0] dc_addr_i,
    input  logic                 dc_wb_i,
    input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
    input  logic [LANE_SIZE-1:0] dc_wb_data_i,
    output logic                 dc_rdy_o,
    output logic [LANE_SIZE-1:0] dc_data_o,
    output logic [ADDR_SIZE-1:0] dc_addr_o,
    input  logic                 ic_miss_i,
    input  logic [ADDR_SIZE-1:0] ic_addr_i,
    output logic                 ic_rdy_o,
    output logic [LANE_SIZE-1:0] ic_data_o,
    output logic [ADDR_SIZE-1:0] ic_addr_o,
    output logic                 mem_rd_o,
    output logic                 mem_wr_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    output logic [LANE_SIZE-1:0] mem_data_o,
    input  logic [LANE_SIZE-1:0] mem_data_i,
    input  logic                 mem_rdy_i
);

    function automatic logic [ADDR_SIZE-1:0] lane_align(
        input logic [ADDR_SIZE-1:0] a
    );
        return a & ~(ADDR_SIZE'(DCACHE_BYTE_SIZE - 1));
    endfunction

    mmu_state_e           state_q, state_d;
    logic [ADDR_SIZE-1:0] req_addr_q, req_addr_d;
    logic                 mem_rd_d, mem_wr_d;
    logic [ADDR_SIZE-1:0] mem_addr_d;
    logic [LANE_SIZE-1:0] mem_data_d;
    logic                 grant_dc, grant_ic;

`ifdef SEGRE_MEM_ARB_RR_EN
    // rr_dc_q set means dcache wins the next conflict
    logic rr_dc_q, rr_dc_d;

    // Conflicts go to whichever side was not served last
    always_comb begin
        grant_dc = dc_miss_i && (!ic_miss_i || rr_dc_q);
        grant_ic = ic_miss_i && !grant_dc;
    end
`else
    // Fixed priority: dcache always beats icache
    always_comb begin
        grant_dc = dc_miss_i;
        grant_ic = ic_miss_i && !dc_miss_i;
    end
`endif

    // Next state and next values of the registered memory port
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        mem_rd_d   = mem_rd_o;
        mem_wr_d   = mem_wr_o;
        mem_addr_d = mem_addr_o;
        mem_data_d = mem_data_o;
`ifdef SEGRE_MEM_ARB_RR_EN
        rr_dc_d    = rr_dc_q;
`endif
        unique case (state_q)
            MMU_IDLE: begin
                if (grant_dc) begin
                    req_addr_d = lane_align(dc_addr_i);
`ifdef SEGRE_MEM_ARB_RR_EN
                    rr_dc_d    = 1'b0;
`endif
                    if (dc_wb_i) begin
                        state_d    = DCACHE_WB;
                        mem_wr_d   = 1'b1;
                        mem_addr_d = lane_align(dc_wb_addr_i);
                        mem_data_d = dc_wb_data_i;
                    end else begin
                        state_d    = DCACHE_REQ;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = lane_align(dc_addr_i);
                    end
                end else if (grant_ic) begin
                    state_d    = ICACHE_REQ;
                    req_addr_d = lane_align(ic_addr_i);
                    mem_rd_d   = 1'b1;
                    mem_addr_d = lane_align(ic_addr_i);
`ifdef SEGRE_MEM_ARB_RR_EN
                    rr_dc_d    = 1'b1;
`endif
                end
            end
            DCACHE_WB: begin
                if (mem_rdy_i) begin
                    state_d    = DCACHE_REQ;
                    mem_wr_d   = 1'b0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = req_addr_q;
                end
            end
            DCACHE_REQ, ICACHE_REQ: begin
                if (mem_rdy_i) begin
                    state_d    = MMU_IDLE;
                    mem_rd_d   = 1'b0;
                    mem_addr_d = '0;
                    mem_data_d = '0;
                end
            end
            default: state_d = MMU_IDLE;
        endcase
    end

    // State, captured request address and memory port registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= MMU_IDLE;
            req_addr_q <= '0;
            mem_rd_o   <= 1'b0;
            mem_wr_o   <= 1'b0;
            mem_addr_o <= '0;
            mem_data_o <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            mem_rd_o   <= mem_rd_d;
            mem_wr_o   <= mem_wr_d;
            mem_addr_o <= mem_addr_d;
            mem_data_o <= mem_data_d;
        end
    end

`ifdef SEGRE_MEM_ARB_RR_EN
    // Round-robin pointer, favouring dcache out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) rr_dc_q <= 1'b1;
        else       rr_dc_q <= rr_dc_d;
    end
`endif

    // Completion pulses follow mem_rdy_i in the same cycle
    always_comb begin
        dc_rdy_o  = (state_q == DCACHE_REQ) && mem_rdy_i;
        ic_rdy_o  = (state_q == ICACHE_REQ) && mem_rdy_i;
        dc_data_o = dc_rdy_o ? mem_data_i : '0;
        dc_addr_o = dc_rdy_o ? req_addr_q : '0;
        ic_data_o = ic_rdy_o ? mem_data_i : '0;
        ic_addr_o = ic_rdy_o ? req_addr_q : '0;
    end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// tb_segre_mem_arbiter: directed vector table, reset-abort sequence and
// randomized traffic against a transaction-level reference model.
module tb_segre_mem_arbiter;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         dc_miss_i;
    logic [31:0]  dc_addr_i;
    logic         dc_wb_i;
    logic [31:0]  dc_wb_addr_i;
    logic [127:0] dc_wb_data_i;
    logic         dc_rdy_o;
    logic [127:0] dc_data_o;
    logic [31:0]  dc_addr_o;
    logic         ic_miss_i;
    logic [31:0]  ic_addr_i;
    logic         ic_rdy_o;
    logic [127:0] ic_data_o;
    logic [31:0]  ic_addr_o;
    logic         mem_rd_o;
    logic         mem_wr_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_data_o;
    logic [127:0] mem_data_i;
    logic         mem_rdy_i;

    segre_mem_arbiter #(.ADDR_SIZE(32), .LANE_SIZE(128)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .dc_miss_i(dc_miss_i), .dc_addr_i(dc_addr_i),
        .dc_wb_i(dc_wb_i), .dc_wb_addr_i(dc_wb_addr_i),
        .dc_wb_data_i(dc_wb_data_i),
        .dc_rdy_o(dc_rdy_o), .dc_data_o(dc_data_o), .dc_addr_o(dc_addr_o),
        .ic_miss_i(ic_miss_i), .ic_addr_i(ic_addr_i),
        .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o), .ic_addr_o(ic_addr_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_rdy_i(mem_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic rst; logic dcm; logic [31:0] dca; logic wb;
        logic [31:0] wba; logic [127:0] wbd; logic icm; logic [31:0] ica;
        logic mrdy; logic [127:0] mdat;
        logic e_rd; logic e_wr; logic [31:0] e_ma; logic [127:0] e_md;
        logic e_dr; logic e_ir; logic [31:0] e_ra; logic [127:0] e_dat;
    } vec_t;

    typedef struct {
        bit wr; logic [31:0] a; logic [127:0] d;
    } op_t;

    function automatic logic [31:0] align16(input logic [31:0] a);
        return (a / 32'd16) * 32'd16;
    endfunction

    function automatic vec_t zrow();
        vec_t v;
        v = '{default: '0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst_i        = v.rst;
        dc_miss_i    = v.dcm;
        dc_addr_i    = v.dca;
        dc_wb_i      = v.wb;
        dc_wb_addr_i = v.wba;
        dc_wb_data_i = v.wbd;
        ic_miss_i    = v.icm;
        ic_addr_i    = v.ica;
        mem_rdy_i    = v.mrdy;
        mem_data_i   = v.mdat;
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        bit bad;
        bad = (mem_rd_o !== v.e_rd) || (mem_wr_o !== v.e_wr) ||
              (dc_rdy_o !== v.e_dr) || (ic_rdy_o !== v.e_ir);
        if ((v.e_rd || v.e_wr) && mem_addr_o !== v.e_ma) bad = 1;
        if (v.e_wr && mem_data_o !== v.e_md) bad = 1;
        if (v.e_dr && (dc_addr_o !== v.e_ra || dc_data_o !== v.e_dat)) bad = 1;
        if (v.e_ir && (ic_addr_o !== v.e_ra || ic_data_o !== v.e_dat)) bad = 1;
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL row%0d: got rd=%b wr=%b ma=%h dr=%b ir=%b da=%h ia=%h want rd=%b wr=%b ma=%h dr=%b ir=%b ra=%h",
                     idx, mem_rd_o, mem_wr_o, mem_addr_o, dc_rdy_o, ic_rdy_o,
                     dc_addr_o, ic_addr_o, v.e_rd, v.e_wr, v.e_ma,
                     v.e_dr, v.e_ir, v.e_ra);
        end
    endtask

    vec_t tbl[$];

    task automatic build_table();
        vec_t v;
        v = zrow(); v.rst = 1; tbl.push_back(v);
        v = zrow(); v.dcm = 1; v.dca = 32'h0000_1234; tbl.push_back(v);
        v.e_rd = 1; v.e_ma = 32'h0000_1230; tbl.push_back(v);
        v.dcm = 0; v.dca = 32'hFFFF_FFFF; tbl.push_back(v);
        tbl.push_back(v);
        v.mrdy = 1; v.mdat = {4{32'hD0D0_0001}};
        v.e_dr = 1; v.e_ra = 32'h0000_1230; v.e_dat = v.mdat;
        tbl.push_back(v);
        v = zrow(); tbl.push_back(v);
        v = zrow(); v.dcm = 1; v.dca = 32'h0000_3004; v.wb = 1;
        v.wba = 32'h0000_2008; v.wbd = {4{32'hA5A5_A5A5}}; tbl.push_back(v);
        v.wba = 32'h0000_FFF0; v.wbd = '0; v.mrdy = 1;
        v.e_wr = 1; v.e_ma = 32'h0000_2000; v.e_md = {4{32'hA5A5_A5A5}};
        tbl.push_back(v);
        v = zrow(); v.dcm = 1; v.dca = 32'h0000_3004; v.wb = 1;
        v.e_rd = 1; v.e_ma = 32'h0000_3000; tbl.push_back(v);
        v.mrdy = 1; v.mdat = {4{32'hD1D1_0002}};
        v.e_dr = 1; v.e_ra = 32'h0000_3000; v.e_dat = v.mdat;
        tbl.push_back(v);
        v = zrow(); tbl.push_back(v);
        v = zrow(); v.dcm = 1; v.dca = 32'h0000_4000;
        v.icm = 1; v.ica = 32'h0000_5008; tbl.push_back(v);
        v.mrdy = 1; v.mdat = {4{32'hD2D2_0003}};
        v.e_rd = 1; v.e_ma = 32'h0000_4000;
        v.e_dr = 1; v.e_ra = 32'h0000_4000; v.e_dat = v.mdat;
        tbl.push_back(v);
        v = zrow(); v.icm = 1; v.ica = 32'h0000_5008; tbl.push_back(v);
        v.mrdy = 1; v.mdat = {4{32'hD3D3_0004}};
        v.e_rd = 1; v.e_ma = 32'h0000_5000;
        v.e_ir = 1; v.e_ra = 32'h0000_5000; v.e_dat = v.mdat;
        tbl.push_back(v);
        v = zrow(); tbl.push_back(v);
        v = zrow(); v.mrdy = 1; v.mdat = {4{32'hD4D4_0005}};
        tbl.push_back(v);
        v = zrow(); tbl.push_back(v);
    endtask

    task automatic reset_abort_seq();
        bit seen;
        bit dc_seen;
        vec_t v;
        v = zrow(); v.dcm = 1; v.dca = 32'h0000_7000;
        @(negedge clk_i); drive(v);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk_i);
            if (mem_rd_o) seen = 1;
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL rst_setup: mem_rd_o never rose, want 1");
        end
        #1;
        mem_rdy_i  = 1;
        mem_data_i = {4{32'hEEEE_0006}};
        rst_i      = 1;
        #1;
        tests++;
        if (mem_rd_o || mem_wr_o || dc_rdy_o || ic_rdy_o ||
            mem_addr_o != 0 || mem_data_o != 0) begin
            fails++;
            $display("FAIL rst_abort: rd=%b wr=%b dr=%b ir=%b ma=%h, want all 0",
                     mem_rd_o, mem_wr_o, dc_rdy_o, ic_rdy_o, mem_addr_o);
        end
        @(negedge clk_i);
        v = zrow(); v.icm = 1; v.ica = 32'h0000_601C;
        drive(v);
        seen = 0;
        dc_seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            mem_rdy_i  = mem_rd_o;
            mem_data_i = {4{32'hC0DE_0007}};
            #1;
            if (dc_rdy_o) dc_seen = 1;
            if (ic_rdy_o) begin
                seen = 1;
                tests++;
                if (ic_addr_o !== 32'h0000_6010 ||
                    ic_data_o !== {4{32'hC0DE_0007}}) begin
                    fails++;
                    $display("FAIL rst_recover: ia=%h id=%h want 00006010 c0de0007",
                             ic_addr_o, ic_data_o);
                end
            end
        end
        tests++;
        if (!seen || dc_seen) begin
            fails++;
            $display("FAIL rst_recover_done: ic_rdy seen=%b dc_rdy seen=%b, want 1 0",
                     seen, dc_seen);
        end
        @(negedge clk_i);
        drive(zrow());
    endtask

    task automatic random_phase(input int cycles);
        bit dc_pend, ic_pend, drop_dc, drop_ic, busy, who;
        logic [31:0] dc_a, dc_wa, ic_a;
        logic dc_w;
        logic [127:0] dc_wd;
        op_t ops[$];
        op_t op;
        bit e_rd, e_wr, e_dr, e_ir, bad;
        dc_pend = 0; ic_pend = 0; drop_dc = 0; drop_ic = 0;
        busy = 0; who = 0;
        dc_a = 0; dc_wa = 0; ic_a = 0; dc_w = 0; dc_wd = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            if (!dc_pend && $urandom_range(0, 3) == 0) begin
                dc_pend = 1; drop_dc = 0;
                dc_a = $urandom; dc_wa = $urandom;
                dc_w = 1'($urandom_range(0, 1));
                dc_wd = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!ic_pend && $urandom_range(0, 3) == 0) begin
                ic_pend = 1; drop_ic = 0; ic_a = $urandom;
            end
            if (busy && who == 0) begin
                dc_addr_i    = $urandom;
                dc_wb_addr_i = $urandom;
                dc_wb_data_i = {$urandom, $urandom, $urandom, $urandom};
                dc_wb_i      = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) drop_dc = 1;
            end else begin
                dc_addr_i    = dc_a;
                dc_wb_addr_i = dc_wa;
                dc_wb_data_i = dc_wd;
                dc_wb_i      = dc_w;
            end
            if (busy && who == 1) begin
                ic_addr_i = $urandom;
                if ($urandom_range(0, 3) == 0) drop_ic = 1;
            end else begin
                ic_addr_i = ic_a;
            end
            dc_miss_i  = dc_pend && !drop_dc;
            ic_miss_i  = ic_pend && !drop_ic;
            mem_rdy_i  = busy ? ($urandom_range(0, 2) == 0)
                              : ($urandom_range(0, 7) == 0);
            mem_data_i = {$urandom, $urandom, $urandom, $urandom};
            #1;
            e_rd = busy && !ops[0].wr;
            e_wr = busy && ops[0].wr;
            e_dr = busy && who == 0 && mem_rdy_i && ops.size() == 1;
            e_ir = busy && who == 1 && mem_rdy_i && ops.size() == 1;
            bad = (mem_rd_o !== e_rd) || (mem_wr_o !== e_wr) ||
                  (dc_rdy_o !== e_dr) || (ic_rdy_o !== e_ir);
            if (busy && mem_addr_o !== ops[0].a) bad = 1;
            if (e_wr && mem_data_o !== ops[0].d) bad = 1;
            if (e_dr && (dc_addr_o !== ops[0].a || dc_data_o !== mem_data_i))
                bad = 1;
            if (e_ir && (ic_addr_o !== ops[0].a || ic_data_o !== mem_data_i))
                bad = 1;
            tests++;
            if (bad) begin
                fails++;
                $display("FAIL rand%0d: got rd=%b wr=%b ma=%h dr=%b ir=%b want rd=%b wr=%b ma=%h dr=%b ir=%b",
                         c, mem_rd_o, mem_wr_o, mem_addr_o, dc_rdy_o, ic_rdy_o,
                         e_rd, e_wr, busy ? ops[0].a : 32'h0, e_dr, e_ir);
            end
            if (busy) begin
                if (mem_rdy_i) begin
                    void'(ops.pop_front());
                    if (ops.size() == 0) begin
                        busy = 0;
                        if (who == 0) dc_pend = 0;
                        else          ic_pend = 0;
                    end
                end
            end else if (dc_miss_i) begin
                busy = 1; who = 0;
                if (dc_wb_i) begin
                    op = '{wr: 1'b1, a: align16(dc_wb_addr_i), d: dc_wb_data_i};
                    ops.push_back(op);
                end
                op = '{wr: 1'b0, a: align16(dc_addr_i), d: '0};
                ops.push_back(op);
            end else if (ic_miss_i) begin
                busy = 1; who = 1;
                op = '{wr: 1'b0, a: align16(ic_addr_i), d: '0};
                ops.push_back(op);
            end
        end
    endtask

    initial begin
        drive(zrow());
        rst_i = 1;
        repeat (2) @(negedge clk_i);
        build_table();
        foreach (tbl[i]) begin
            @(negedge clk_i);
            drive(tbl[i]);
            #1;
            check_vec(tbl[i], i);
        end
        reset_abort_seq();
        @(negedge clk_i);
        rst_i = 1;
        @(negedge clk_i);
        rst_i = 0;
        random_phase(2000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/segre_mem_arbiter.md
SEGRE_MEM_ARBITER -- requirements
Module: segre_mem_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, default 32, address width; LANE_SIZE, default 128, lane width in bits (16 bytes).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be, in order (name, direction, width, meaning):
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- dc_miss_i  in  1  dcache fill request, held until dc_rdy_o
- dc_addr_i  in  ADDR_SIZE  dcache miss address
- dc_wb_i  in  1  evicted lane is dirty; write back before fill
- dc_wb_addr_i  in  ADDR_SIZE  victim lane address
- dc_wb_data_i  in  LANE_SIZE  victim lane data
- dc_rdy_o  out  1  one-cycle fill-complete pulse
- dc_data_o  out  LANE_SIZE  fill data, valid with dc_rdy_o
- dc_addr_o  out  ADDR_SIZE  lane-aligned fill address, valid with dc_rdy_o
- ic_miss_i  in  1  icache fill request, held until ic_rdy_o
- ic_addr_i  in  ADDR_SIZE  icache miss address
- ic_rdy_o  out  1  one-cycle fill-complete pulse
- ic_data_o  out  LANE_SIZE  fill data, valid with ic_rdy_o
- ic_addr_o  out  ADDR_SIZE  lane-aligned fill address, valid with ic_rdy_o
- mem_rd_o  out  1  memory lane read request
- mem_wr_o  out  1  memory lane write request
- mem_addr_o  out  ADDR_SIZE  lane-aligned memory address
- mem_data_o  out  LANE_SIZE  write data
- mem_data_i  in  LANE_SIZE  read data, valid with mem_rdy_i
- mem_rdy_i  in  1  memory completes current request (one-cycle pulse)

Function
REQ-004 FSM states SHALL be MMU_IDLE, DCACHE_WB, DCACHE_REQ, ICACHE_REQ.
REQ-005 MMU_IDLE SHALL grant one pending request per cycle; dc_miss_i with dc_wb_i -> DCACHE_WB; dc_miss_i without dc_wb_i -> DCACHE_REQ; else ic_miss_i -> ICACHE_REQ; else stay.
REQ-006 Default arbitration SHALL be fixed priority dcache over icache.
REQ-007 Memory outputs SHALL be registered; mem_rd_o/mem_wr_o asserted from the cycle after grant and held constant until mem_rdy_i.
REQ-008 DCACHE_WB SHALL drive mem_wr_o=1, mem_addr_o=dc_wb_addr_i aligned, mem_data_o=dc_wb_data_i (captured at grant); on mem_rdy_i -> DCACHE_REQ without returning to idle.
REQ-009 DCACHE_REQ/ICACHE_REQ SHALL drive mem_rd_o=1 with captured aligned address; on mem_rdy_i pulse the matching rdy_o for exactly that cycle with data_o=mem_data_i, addr_o=captured address, and return to MMU_IDLE.
REQ-010 Alignment SHALL clear address bits [3:0]; request addresses SHALL be captured at grant; later input changes ignored.
REQ-011 mem_rd_o and mem_wr_o SHALL never be high together; at most one of dc_rdy_o/ic_rdy_o high per cycle.
REQ-012 mem_rdy_i in MMU_IDLE SHALL be ignored.
REQ-013 A requester dropping miss_i before its rdy_o SHALL not abort the transaction; completion still pulses rdy_o.
REQ-014 Back-to-back: minimum grant-to-rdy latency is 2 cycles (read) and 3 cycles (writeback+read) with single-cycle memory; a new grant may occur the cycle after a rdy_o pulse.

Reset
REQ-015 rst_i SHALL asynchronously force MMU_IDLE and all outputs to 0, including mid-transaction; the in-flight request is dropped with no rdy_o pulse.
REQ-016 Round-robin pointer (if compiled) SHALL reset to favour dcache.

Configuration
REQ-017 Macro SEGRE_MEM_ARB_RR_EN defined: when both dc_miss_i and ic_miss_i pend in MMU_IDLE, grant SHALL alternate, the last-served requester losing; pointer updates on each grant.
REQ-018 Macro undefined: fixed priority per REQ-006; no pointer register exists.

Structure
REQ-019 Shared package SHALL hold the state enum (extended with DCACHE_WB) and lane-offset constant DCACHE_BYTE_SIZE; no local duplicates.
REQ-020 Single module; no sub-module.

Verification
REQ-021 dc_miss_i=1, dc_addr_i=0x0000_1234, mem_rdy_i 3 cycles after mem_rd_o -> mem_addr_o=0x0000_1230, dc_rdy_o one-cycle pulse, dc_data_o=mem_data_i.
REQ-022 dc_miss_i with dc_wb_i=1, dc_wb_addr_i=0x0000_2008, dc_wb_data_i=0xA5..A5 -> mem_wr_o to 0x0000_2000 with 0xA5..A5, then mem_rd_o to dcache address, one dc_rdy_o.
REQ-023 dc_miss_i and ic_miss_i asserted same cycle -> dcache served first, then icache; with SEGRE_MEM_ARB_RR_EN over 4 mixed conflicts grants alternate.
REQ-024 rst_i asserted while mem_rd_o=1 -> all outputs 0 same cycle, no rdy_o; after release ic_miss_i served normally.
REQ-025 mem_rdy_i pulse in MMU_IDLE with no miss pending -> no rdy_o, no state change.
